// File: rtl/io_periph_if.sv
// IO-bus connection between the memory unit (master) and an IO responder (slave).
// Handshake: io_en acts as valid with an implied ready that is always 1; every strobed
// cycle completes at its rising edge, and read data appears on io_data_read one cycle later.
interface io_periph_if;
  logic [7:0]  io_addr;
  logic        io_en;
  logic        io_we;
  logic [31:0] io_data_write;
  logic [31:0] io_data_read;

  modport master (
    output io_addr, io_en, io_we, io_data_write,
    input  io_data_read
  );

  modport slave (
    input  io_addr, io_en, io_we, io_data_write,
    output io_data_read
  );
endinterface

// File: rtl/io_periph.sv
// IO peripheral: ID, GPIO with input synchronizer, free-running/auto-reload timer with
// match interrupt, and a 16-word scratch RAM, all on a never-stalling word-addressed bus.
module io_periph #(
  parameter int GPIO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetb,
  io_periph_if.slave            bus,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  irq
);

  localparam logic [31:0] ID_VALUE   = 32'h494F_0001;
  localparam logic [7:0]  A_ID       = 8'h00;
  localparam logic [7:0]  A_GPIO_OUT = 8'h01;
  localparam logic [7:0]  A_GPIO_IN  = 8'h02;
  localparam logic [7:0]  A_TCTRL    = 8'h03;
  localparam logic [7:0]  A_TCOUNT   = 8'h04;
  localparam logic [7:0]  A_TCMP     = 8'h05;
  localparam logic [7:0]  A_STATUS   = 8'h06;

  logic [7:0]            addr;
  logic [31:0]           wdata;
  logic                  wr_en;
  logic                  rd_en;
  logic                  is_scratch;

  logic [GPIO_WIDTH-1:0] sync_q1;
  logic [GPIO_WIDTH-1:0] sync_q2;
  logic [2:0]            tctrl;
  logic [31:0]           tcount;
  logic [31:0]           tcount_nxt;
  logic [31:0]           tcmp;
  logic                  match_q;
  logic                  match_nxt;
  logic                  match_hit;
  logic [31:0]           scratch [16];
  logic [31:0]           rd_val;

  logic t_en;
  logic t_auto;
  logic t_irqen;

  assign addr       = bus.io_addr;
  assign wdata      = bus.io_data_write;
  assign wr_en      = bus.io_en & bus.io_we;
  assign rd_en      = bus.io_en & ~bus.io_we;
  assign is_scratch = (addr[7:4] == 4'h1);

  assign t_en    = tctrl[0];
  assign t_auto  = tctrl[1];
  assign t_irqen = tctrl[2];

  // Match is judged on the pre-edge count, so it is seen the cycle after TCOUNT==TCMP.
  assign match_hit = t_en && (tcount == tcmp);

  always_comb begin
    tcount_nxt = tcount;
    if (wr_en && (addr == A_TCOUNT)) begin
      tcount_nxt = wdata;
    end else if (t_en) begin
      tcount_nxt = (match_hit && t_auto) ? 32'd0 : tcount + 32'd1;
    end
  end

  // A new match outranks a simultaneous write-1-to-clear.
  always_comb begin
    match_nxt = match_q;
    if (wr_en && (addr == A_STATUS) && wdata[0]) match_nxt = 1'b0;
    if (match_hit) match_nxt = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      A_ID:       rd_val = ID_VALUE;
      A_GPIO_OUT: rd_val[GPIO_WIDTH-1:0] = gpio_out;
      A_GPIO_IN:  rd_val[GPIO_WIDTH-1:0] = sync_q2;
      A_TCTRL:    rd_val[2:0] = tctrl;
      A_TCOUNT:   rd_val = tcount;
      A_TCMP:     rd_val = tcmp;
      A_STATUS:   rd_val[0] = match_q;
      default:    if (is_scratch) rd_val = scratch[addr[3:0]];
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_q1          <= '0;
      sync_q2          <= '0;
      gpio_out         <= '0;
      tctrl            <= '0;
      tcount           <= '0;
      tcmp             <= '0;
      match_q          <= 1'b0;
      bus.io_data_read <= '0;
    end else begin
      sync_q1 <= gpio_in;
      sync_q2 <= sync_q1;
      tcount  <= tcount_nxt;
      match_q <= match_nxt;
      if (wr_en) begin
        case (addr)
          A_GPIO_OUT: gpio_out <= wdata[GPIO_WIDTH-1:0];
          A_TCTRL:    tctrl    <= wdata[2:0];
          A_TCMP:     tcmp     <= wdata;
          default:    ;
        endcase
      end
      if (rd_en) bus.io_data_read <= rd_val;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 16; i++) scratch[i] <= '0;
    end else if (wr_en && is_scratch) begin
      scratch[addr[3:0]] <= wdata;
    end
  end

  // Both terms are flops, so irq has no combinational path from the bus.
  assign irq = match_q & t_irqen;

endmodule

// File: tb/tb_io_periph.sv
// Directed bench for io_periph: a register-map model checked every cycle, plus
// hand-computed literal expectations for the bus, GPIO, timer and reset scenarios.
module tb_io_periph;
  localparam int GW = 16;

  logic          clk_tb = 1'b0;
  logic          resetb;
  logic [GW-1:0] gpio_in;
  logic [GW-1:0] gpio_out;
  logic          irq;

  int errors = 0;
  int checks = 0;

  io_periph_if bus ();

  io_periph #(.GPIO_WIDTH(GW)) dut (
    .clk      (clk_tb),
    .resetb   (resetb),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .irq      (irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_tb = ~clk_tb;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model of the register map ----------------
  logic [31:0] m_scratch [16];
  logic [GW-1:0] m_gpio_out, m_s1, m_s2;
  logic [2:0]  m_tctrl;
  logic [31:0] m_tcount, m_tcmp, m_rdata;
  logic        m_match, m_hit, m_wr, m_rd;
  logic [7:0]  m_a;
  logic [31:0] m_d;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] model_read(input logic [7:0] a);
    if (a == 8'h00) return 32'h494F_0001;
    if (a == 8'h01) return 32'(m_gpio_out);
    if (a == 8'h02) return 32'(m_s2);
    if (a == 8'h03) return 32'(m_tctrl);
    if (a == 8'h04) return m_tcount;
    if (a == 8'h05) return m_tcmp;
    if (a == 8'h06) return 32'(m_match);
    if (a >= 8'h10 && a <= 8'h1F) return m_scratch[a[3:0]];
    return 32'h0;
  endfunction

  always @(posedge clk_tb or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 16; i++) m_scratch[i] = '0;
      m_gpio_out = '0; m_s1 = '0; m_s2 = '0;
      m_tctrl = '0; m_tcount = '0; m_tcmp = '0; m_match = 1'b0; m_rdata = '0;
      exp_q.delete();
    end else begin
      m_a  = bus.io_addr;
      m_d  = bus.io_data_write;
      m_wr = bus.io_en && bus.io_we;
      m_rd = bus.io_en && !bus.io_we;
      if (m_rd) begin
        m_rdata = model_read(m_a);
        exp_q.push_back(m_rdata);
      end
      m_hit = m_tctrl[0] && (m_tcount == m_tcmp);
      if (m_wr && m_a == 8'h04)  m_tcount = m_d;
      else if (m_tctrl[0])       m_tcount = (m_hit && m_tctrl[1]) ? 32'h0 : m_tcount + 1;
      if (m_wr && m_a == 8'h06 && m_d[0]) m_match = 1'b0;
      if (m_hit) m_match = 1'b1;
      m_s2 = m_s1;
      m_s1 = gpio_in;
      if (m_wr) begin
        if (m_a == 8'h01) m_gpio_out = m_d[GW-1:0];
        if (m_a == 8'h03) m_tctrl = m_d[2:0];
        if (m_a == 8'h05) m_tcmp = m_d;
        if (m_a >= 8'h10 && m_a <= 8'h1F) m_scratch[m_a[3:0]] = m_d;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_tb) begin
    if (resetb === 1'b1) begin
      if (exp_q.size() > 0) check32("rd_model", bus.io_data_read, exp_q.pop_front());
      else                  check32("rd_hold", bus.io_data_read, m_rdata);
      check32("gpio_model", 32'(gpio_out), 32'(m_gpio_out));
      check32("irq_model", {31'b0, irq}, {31'b0, m_match & m_tctrl[2]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk_tb);
    bus.io_addr = a; bus.io_data_write = d; bus.io_we = 1'b1; bus.io_en = 1'b1;
    @(posedge clk_tb);
    #1 bus.io_en = 1'b0; bus.io_we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string name);
    @(negedge clk_tb);
    bus.io_addr = a; bus.io_we = 1'b0; bus.io_en = 1'b1;
    @(posedge clk_tb);
    #1 bus.io_en = 1'b0;
    check32(name, bus.io_data_read, exp);
  endtask

  logic [31:0] exp_auto [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2, 32'd3};
  logic [31:0] exp_wrap [8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1,
                                32'd2, 32'd3, 32'd4, 32'd5};

  // ---------------- directed stimulus ----------------
  initial begin
    resetb = 1'b0;
    gpio_in = '0;
    bus.io_addr = '0; bus.io_en = 1'b0; bus.io_we = 1'b0; bus.io_data_write = '0;
    repeat (2) @(posedge clk_tb);
    #1;
    check32("rst_rdata", bus.io_data_read, 32'h0);
    check32("rst_gpio", 32'(gpio_out), 32'h0);
    check32("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk_tb); #2 resetb = 1'b1;

    // register file, ID, unmapped, read-data hold
    bus_write(8'h10, 32'hA5A5_0001);
    bus_write(8'h1F, 32'hDEAD_BEEF);
    bus_write(8'h00, 32'h1234_0000);
    bus_write(8'h07, 32'hFFFF_FFFF);
    bus_read(8'h10, 32'hA5A5_0001, "scratch_10");
    bus_read(8'h00, 32'h494F_0001, "id");
    bus_read(8'h07, 32'h0, "unmapped_07");
    bus_read(8'h1F, 32'hDEAD_BEEF, "scratch_1f");
    bus_write(8'h11, 32'h0000_0005);
    check32("rd_hold_write", bus.io_data_read, 32'hDEAD_BEEF);
    check32("model_scratch", m_scratch[0], 32'hA5A5_0001);

    // GPIO out / in
    bus_write(8'h01, 32'h1234_5678);
    check32("gpio_out", 32'(gpio_out), 32'h0000_5678);
    bus_read(8'h01, 32'h0000_5678, "gpio_out_rd");
    #2 gpio_in = 16'hBEEF;
    bus_read(8'h02, 32'h0, "gpio_in_early");
    @(posedge clk_tb);
    bus_read(8'h02, 32'h0000_BEEF, "gpio_in_sync");

    // TCTRL upper bits discarded, read-after-write
    bus_write(8'h03, 32'hFFFF_FFF4);
    bus_read(8'h03, 32'h0000_0004, "tctrl_raw");
    bus_write(8'h03, 32'h0);

    // auto-reload timer
    bus_write(8'h05, 32'd3);
    bus_write(8'h03, 32'h7);
    for (int i = 0; i < 8; i++) begin
      bus_read(8'h04, exp_auto[i], "tcount_auto");
      check32("irq_auto", {31'b0, irq}, (i >= 3) ? 32'h1 : 32'h0);
    end
    bus_write(8'h06, 32'h1);
    check32("irq_cleared", {31'b0, irq}, 32'h0);
    bus_read(8'h04, 32'd1, "tcount_after_clr");
    bus_read(8'h04, 32'd2, "tcount_after_clr");
    bus_write(8'h06, 32'h1);
    check32("irq_set_wins", {31'b0, irq}, 32'h1);
    bus_read(8'h06, 32'h1, "status_set_wins");
    bus_write(8'h03, 32'h0);
    bus_write(8'h06, 32'h1);
    check32("irq_off", {31'b0, irq}, 32'h0);
    check32("model_frozen", m_tcount, 32'd2);
    bus_read(8'h04, 32'd2, "tcount_frozen");
    bus_read(8'h04, 32'd2, "tcount_frozen");

    // wrap-around, no interrupt enable
    bus_write(8'h04, 32'hFFFF_FFFE);
    bus_write(8'h05, 32'd5);
    bus_write(8'h03, 32'h1);
    for (int i = 0; i < 8; i++) bus_read(8'h04, exp_wrap[i], "tcount_wrap");
    bus_read(8'h06, 32'h1, "status_wrap");
    check32("irq_wrap", {31'b0, irq}, 32'h0);
    bus_read(8'h04, 32'd7, "tcount_no_reload");

    // reset in mid-operation
    bus_write(8'h01, 32'h0000_FFFF);
    check32("gpio_ffff", 32'(gpio_out), 32'h0000_FFFF);
    bus_read(8'h10, 32'hA5A5_0001, "pre_rst_rd");
    bus_write(8'h03, 32'h5);
    check32("pre_rst_irq", {31'b0, irq}, 32'h1);
    @(negedge clk_tb); #2 resetb = 1'b0;
    #1;
    check32("async_rst_rdata", bus.io_data_read, 32'h0);
    check32("async_rst_gpio", 32'(gpio_out), 32'h0);
    check32("async_rst_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(posedge clk_tb);
    @(negedge clk_tb); #2 resetb = 1'b1;
    bus_read(8'h04, 32'h0, "post_rst_tcount");
    bus_read(8'h03, 32'h0, "post_rst_tctrl");
    bus_read(8'h01, 32'h0, "post_rst_gpio");
    bus_read(8'h10, 32'h0, "post_rst_scratch");
    bus_read(8'h1F, 32'h0, "post_rst_scratch");
    bus_read(8'h06, 32'h0, "post_rst_status");
    bus_read(8'h04, 32'h0, "post_rst_idle");
    check32("model_post_rst", m_tcount, 32'h0);

    repeat (2) @(posedge clk_tb);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_periph.md
IO_PERIPH -- requirements
Module: io_periph

Interface
REQ-001 Parameter GPIO_WIDTH, default 16: width of the GPIO in/out ports, 1..32.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetb  input  1  asynchronous, active-low reset.
REQ-004 io_addr  input  8  word address of the IO register accessed.
REQ-005 io_en  input  1  access strobe; one access per cycle while high.
REQ-006 io_we  input  1  1 = write, 0 = read; qualified by io_en.
REQ-007 io_data_write  input  32  write data from the memory unit.
REQ-008 io_data_read  output  32  registered read data returned to the memory unit.
REQ-009 gpio_in  input  GPIO_WIDTH  asynchronous external inputs.
REQ-010 gpio_out  output  GPIO_WIDTH  registered external outputs.
REQ-011 irq  output  1  timer interrupt request, level.

Function
REQ-012 The block is the IO-bus responder; it never stalls, and every io_en cycle completes in that cycle.
REQ-013 Register map (word addresses):
- 0x00 ID, RO, 0x494F_0001
- 0x01 GPIO_OUT, RW, low GPIO_WIDTH bits
- 0x02 GPIO_IN, RO
- 0x03 TCTRL, RW: bit0 EN, bit1 AUTORELOAD, bit2 IRQEN
- 0x04 TCOUNT, RW
- 0x05 TCMP, RW
- 0x06 STATUS: bit0 MATCH, write-1-to-clear
- 0x10-0x1F scratch, 16 x 32-bit RW
REQ-014 Unmapped addresses read 0x0000_0000; writes to them and to RO registers are ignored.
REQ-015 Unused upper bits of every register read as 0; bits written there are discarded.
REQ-016 Write: io_en=1 and io_we=1 at a rising edge updates the addressed register at that edge.
REQ-017 Read: io_en=1 and io_we=0 at edge N loads io_data_read with the addressed value at edge N; the value is valid after edge N, giving 1-cycle latency.
REQ-018 io_data_read holds its last value in cycles without a read, including write cycles.
REQ-019 GPIO_IN is sampled through a two-flop synchronizer; a read returns the second-stage value, so an input change is visible 2 edges after it becomes stable.
REQ-020 Timer count: TCOUNT increments by 1 each cycle while EN=1 and wraps from 0xFFFF_FFFF to 0.
REQ-021 Timer match:
- Condition: EN=1 and TCOUNT==TCMP.
- Effect: MATCH sets at the next edge.
- With AUTORELOAD=1, TCOUNT loads 0 at that edge instead of incrementing.
REQ-022 A software write to TCOUNT overrides the increment or reload in the same cycle.
REQ-023 A MATCH set and a W1C clear in the same cycle leave MATCH=1 (set wins).
REQ-024 Clearing EN freezes TCOUNT; MATCH holds until cleared by software.
REQ-025 irq = MATCH AND IRQEN, driven from registers only (no combinational path from io_* inputs).
REQ-026 The TCTRL read value reflects the write on the cycle after the write edge; read-after-write on consecutive cycles returns the new value.

Reset
REQ-027 When resetb=0, immediately and independent of clk, clear all of the following to 0:
- registers and scratch
- synchronizer flops
- gpio_out, io_data_read and irq
REQ-028 A reset asserted while the timer is counting aborts the count with no MATCH; operation resumes on the first rising edge after resetb=1, with EN=0.

Verification
REQ-029 Write/read: write 0xA5A5_0001 to 0x10 and 0xDEAD_BEEF to 0x1F; read 0x10, 0x1F, 0x00 and 0x07 -> results 0xA5A5_0001, 0xDEAD_BEEF, 0x494F_0001 and 0x0, each 1 cycle after its read strobe.
REQ-030 GPIO: write 0x1234_5678 to 0x01 -> gpio_out=0x5678 (GPIO_WIDTH=16); drive gpio_in=0xBEEF, then read 0x02 on the 2nd edge after -> 0x0000_BEEF; an earlier read returns the old value.
REQ-031 Auto-reload timer: TCMP=3, TCTRL=0x7 -> TCOUNT runs 0,1,2,3,0,1,2,3; MATCH and irq rise the edge after TCOUNT=3; writing 0x1 to 0x06 clears them; a clear coinciding with a new match leaves MATCH=1.
REQ-032 Wrap: TCOUNT=0xFFFF_FFFE, TCMP=5, TCTRL=0x1 -> 0xFFFF_FFFF, 0, 1, ... with MATCH set after TCOUNT=5; irq stays 0 (IRQEN=0).
REQ-033 Reset mid-operation: assert resetb=0 between edges with the timer running and gpio_out=0xFFFF -> all outputs are 0 before the next edge, and reads after release return 0 for TCOUNT, TCTRL, GPIO_OUT and scratch.
